// File: rtl/frame_scan_generator.sv
// ============================================================================
// frame_scan_generator: raster (x, y) scan with runtime geometry/blanking.
// Optional SCAN_BOTTOM_UP_EN: rows run height-1 down to 0. Rev 1.0
// ============================================================================
`default_nettype none

module frame_scan_generator #(
  parameter int LOC_SIZE   = 16,
  parameter int FRAME_SIZE = 16,
  parameter int BLANK_SIZE = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  start,
  input  logic                  continuous,
  input  logic [LOC_SIZE-1:0]   cfg_width,
  input  logic [LOC_SIZE-1:0]   cfg_height,
  input  logic [BLANK_SIZE-1:0] cfg_hblank,
  input  logic [BLANK_SIZE-1:0] cfg_vblank,
  output logic [LOC_SIZE-1:0]   x,
  output logic [LOC_SIZE-1:0]   y,
  output logic [FRAME_SIZE-1:0] frame,
  output logic                  pixel_valid,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  eol,
  output logic                  eof,
  output logic                  busy,
  output logic                  cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_HBLANK = 2'd2,
    S_VBLANK = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [LOC_SIZE-1:0]   x_q, x_d;
  logic [LOC_SIZE-1:0]   y_q, y_d;
  logic [FRAME_SIZE-1:0] frame_q, frame_d;
  logic [BLANK_SIZE-1:0] blank_q, blank_d;
  logic [LOC_SIZE-1:0]   width_q, width_d;
  logic [LOC_SIZE-1:0]   height_q, height_d;
  logic [BLANK_SIZE-1:0] hblank_q, hblank_d;
  logic [BLANK_SIZE-1:0] vblank_q, vblank_d;
  logic                  cfg_err_q, cfg_err_d;
  logic                  busy_q, busy_d;

  logic                  w_cfg_ok;
  logic                  w_last_col;
  logic                  w_last_row;
  logic [LOC_SIZE-1:0]   w_first_row_cfg;
  logic [LOC_SIZE-1:0]   w_first_row_q;
  logic [LOC_SIZE-1:0]   w_next_row;
  logic                  w_frame_done;

  assign w_cfg_ok   = (cfg_width != '0) && (cfg_height != '0);
  assign w_last_col = (x_q == width_q - LOC_SIZE'(1));

`ifdef SCAN_BOTTOM_UP_EN
  assign w_first_row_cfg = cfg_height - LOC_SIZE'(1);
  assign w_first_row_q   = height_q - LOC_SIZE'(1);
  assign w_last_row      = (y_q == '0);
  assign w_next_row      = y_q - LOC_SIZE'(1);
`else
  assign w_first_row_cfg = '0;
  assign w_first_row_q   = '0;
  assign w_last_row      = (y_q == height_q - LOC_SIZE'(1));
  assign w_next_row      = y_q + LOC_SIZE'(1);
`endif

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    frame_d      = frame_q;
    blank_d      = blank_q;
    width_d      = width_q;
    height_d     = height_q;
    hblank_d     = hblank_q;
    vblank_d     = vblank_q;
    cfg_err_d    = cfg_err_q;
    w_frame_done = 1'b0;

    if (en) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (w_cfg_ok) begin
              state_d  = S_ACTIVE;
              x_d      = '0;
              y_d      = w_first_row_cfg;
              width_d  = cfg_width;
              height_d = cfg_height;
              hblank_d = cfg_hblank;
              vblank_d = cfg_vblank;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
        S_ACTIVE: begin
          if (!w_last_col) begin
            x_d = x_q + LOC_SIZE'(1);
          end else begin
            x_d = '0;
            if (!w_last_row) begin
              y_d = w_next_row;
              if (hblank_q != '0) begin
                state_d = S_HBLANK;
                blank_d = hblank_q;
              end
            end else begin
              frame_d = frame_q + FRAME_SIZE'(1);
              if (vblank_q != '0) begin
                state_d = S_VBLANK;
                blank_d = vblank_q;
              end else begin
                w_frame_done = 1'b1;
              end
            end
          end
        end
        S_HBLANK: begin
          if (blank_q == BLANK_SIZE'(1)) begin
            blank_d = '0;
            state_d = S_ACTIVE;
          end else begin
            blank_d = blank_q - BLANK_SIZE'(1);
          end
        end
        S_VBLANK: begin
          if (blank_q == BLANK_SIZE'(1)) begin
            blank_d      = '0;
            w_frame_done = 1'b1;
          end else begin
            blank_d = blank_q - BLANK_SIZE'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase

      // Frame boundary: either re-arm with freshly latched geometry or park.
      if (w_frame_done) begin
        x_d = '0;
        if (continuous && w_cfg_ok) begin
          state_d  = S_ACTIVE;
          y_d      = w_first_row_cfg;
          width_d  = cfg_width;
          height_d = cfg_height;
          hblank_d = cfg_hblank;
          vblank_d = cfg_vblank;
        end else begin
          state_d = S_IDLE;
          y_d     = '0;
          if (continuous) begin
            cfg_err_d = 1'b1;
          end
        end
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      frame_q   <= '0;
      blank_q   <= '0;
      width_q   <= '0;
      height_q  <= '0;
      hblank_q  <= '0;
      vblank_q  <= '0;
      cfg_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      frame_q   <= frame_d;
      blank_q   <= blank_d;
      width_q   <= width_d;
      height_q  <= height_d;
      hblank_q  <= hblank_d;
      vblank_q  <= vblank_d;
      cfg_err_q <= cfg_err_d;
      busy_q    <= busy_d;
    end
  end

  // Gated by en combinationally so a stalled pixel is never reported twice.
  assign pixel_valid = (state_q == S_ACTIVE) && en;
  assign hsync       = pixel_valid && (x_q == '0);
  assign vsync       = hsync && (y_q == w_first_row_q);
  assign eol         = pixel_valid && w_last_col;
  assign eof         = eol && w_last_row;

  assign x       = x_q;
  assign y       = y_q;
  assign frame   = frame_q;
  assign busy    = busy_q;
  assign cfg_err = cfg_err_q;

endmodule

`default_nettype wire

// File: doc/frame_scan_generator.md
Name: frame_scan_generator

Overview:
- Parametrised successor to the pixel location generator that feeds the detection pipeline (`top`).
- Produces the raster scan position (x, y), the frame count and per-pixel qualifiers for one frame or a continuous stream of frames.
- Geometry and blanking are set at runtime, so the pipeline can be fed with the back-pressure and gaps seen on real video, not only a gapless single image.
- Sits between the pixel source (testbench memory or camera interface) and `top`.

Parameters:
- LOC_SIZE, 16, width of x, y and the geometry inputs.
- FRAME_SIZE, 16, width of the frame counter.
- BLANK_SIZE, 8, width of the blanking-length inputs.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  advance enable; when low all state holds.
- start  in  1  begin a frame from IDLE.
- continuous  in  1  when 1, start the next frame automatically after vertical blanking.
- cfg_width  in  LOC_SIZE  pixels per line.
- cfg_height  in  LOC_SIZE  lines per frame.
- cfg_hblank  in  BLANK_SIZE  idle cycles after each non-final line.
- cfg_vblank  in  BLANK_SIZE  idle cycles after the final line.
- x  out  LOC_SIZE  column of the current pixel.
- y  out  LOC_SIZE  row of the current pixel.
- frame  out  FRAME_SIZE  completed-frame count.
- pixel_valid  out  1  the current (x, y) is an active pixel this cycle.
- hsync  out  1  first pixel of a line.
- vsync  out  1  first pixel of a frame.
- eol  out  1  last pixel of a line.
- eof  out  1  last pixel of a frame.
- busy  out  1  not in IDLE.
- cfg_err  out  1  sticky: a start was attempted with zero width or height.

Behaviour:
- Reset (async, reset_n=0): state IDLE. x=0, y=0, frame=0, cfg_err=0, blank counter=0. All outputs are 0.
- The registered state advances only on a rising clk edge with en=1. With en=0, every register holds.
- pixel_valid = (state==ACTIVE) & en. It is combinational on en so the consumer never sees the same pixel twice across a stall.
- hsync, vsync, eol and eof are each ANDed with pixel_valid.
  - hsync: x==0.
  - vsync: x==0 and y is the first row.
  - eol: x==width-1.
  - eof: eol and y is the last row.
- Geometry and blanking inputs are latched into shadow registers when a frame starts. Changes during a frame take effect at the next frame.
- States: IDLE, ACTIVE, HBLANK, VBLANK.
- IDLE:
  - On en & start with width≠0 and height≠0: go to ACTIVE with x=0 and y=first row. The first pixel is presented on the cycle after the start edge (latency 1).
  - On en & start with width=0 or height=0: set cfg_err and stay in IDLE.
  - cfg_err clears only on reset.
- ACTIVE:
  - x increments each enabled cycle.
  - At x==width-1, x wraps to 0 and the row advances.
  - At the end of a non-final line: go to HBLANK if cfg_hblank≠0, otherwise stay in ACTIVE and start the next line on the next cycle.
  - At the end of the final line (eof): frame increments (modulo 2^FRAME_SIZE), then go to VBLANK if cfg_vblank≠0. Otherwise, if continuous=1, restart ACTIVE at (0, first row) on the next cycle; if not, go to IDLE.
- HBLANK and VBLANK:
  - Count down the latched length; only enabled cycles count.
  - HBLANK returns to ACTIVE.
  - VBLANK goes to ACTIVE for the next frame (re-latching the config) if continuous=1, otherwise to IDLE.
- continuous is sampled at the point the frame ends (eof, or the last VBLANK cycle).
- start is ignored outside IDLE.
- Row order: y counts 0 to height-1 (default build).
- Width rule: width and height up to 2^LOC_SIZE-1. The x counter compares against width-1 and never overflows.
- Reset mid-frame aborts immediately to IDLE. The partial frame is not counted.
- busy = (state≠IDLE), registered.

Optional Feature:
- Macro: SCAN_BOTTOM_UP_EN.
- When defined: the first row is height-1 and y decrements to 0, matching BMP bottom-up row storage. vsync fires at (0, height-1) and eof at (width-1, 0).
- When undefined: top-down scan as above.
- All other timing is identical in both builds.

Test Plan:
- Single frame: width=4, height=2, hblank=2, vblank=3, continuous=0, start pulse. Required response:
  - 8 pixel_valid cycles, x sequence 0,1,2,3,0,1,2,3 with y 0,0,0,0,1,1,1,1.
  - 2-cycle gap between the two lines.
  - eof on (3,1), then 3 VBLANK cycles, then IDLE.
  - frame=1 and busy=0 after 14 cycles.
- Continuous, zero blanking: width=3, height=3, hblank=0, vblank=0, continuous=1. Required response:
  - pixel_valid stays high without gaps.
  - vsync every 9 cycles.
  - frame=4 after 36 valid cycles.
- Stall: as the single-frame case, drive en=0 for 5 cycles while at (2,0). Required response:
  - pixel_valid=0 and x, y held during the stall.
  - (3,0) is presented exactly once after en rises.
  - Total valid count is still 8.
- Config error and reset: start with width=0. Required response: cfg_err=1, busy stays 0. Then pull reset_n low mid-frame; all outputs go to 0 asynchronously and frame=0.
- SCAN_BOTTOM_UP_EN build: width=2, height=3. Required response:
  - y sequence 2,2,1,1,0,0.
  - vsync on (0,2), eof on (1,0).
- Config change mid-frame: change cfg_width from 4 to 6 during frame 0 with continuous=1. Required response: frame 0 keeps 4-pixel lines; frame 1 uses 6-pixel lines.
